// File: rtl/imm_gen_pipe_stage_pkg.sv
// Shared types for the immediate-generation pipeline stage.
//   imm_select_e : immediate format selector from decode. The original five
//                  formats and IMM_UNKNOWN_TYPE keep their encodings; Z and
//                  SHAMT take the two free codes.
//   imm_entry_t  : one buffered result (immediate, sideband tag, illegal flag),
//                  sized for the widest legal configuration.
//   skid_state_e : occupancy of the two-entry skid buffer.
package risc_v_32_i_pkg;

   localparam int IMM_MAX_W = 64;
   localparam int TAG_MAX_W = 16;

   typedef enum logic [2:0] {
      IMM_I_TYPE       = 3'd0,
      IMM_S_TYPE       = 3'd1,
      IMM_B_TYPE       = 3'd2,
      IMM_U_TYPE       = 3'd3,
      IMM_J_TYPE       = 3'd4,
      IMM_UNKNOWN_TYPE = 3'd5,
      IMM_Z_TYPE       = 3'd6,
      IMM_SHAMT_TYPE   = 3'd7
   } imm_select_e;

   typedef struct packed {
      logic [IMM_MAX_W-1:0] imm;
      logic [TAG_MAX_W-1:0] tag;
      logic                 illegal;
   } imm_entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,   // M invalid, S invalid
      ST_ONE   = 2'd1,   // M valid,   S invalid
      ST_FULL  = 2'd2    // M valid,   S valid
   } skid_state_e;

endpackage

// File: rtl/imm_gen_pipe_stage_if.sv
// Decode->stage->execute handshake bundle.
//   Upstream  : flush_i, valid_i, ready_o, instr_i, imm_sel_i, tag_i
//   Downstream: valid_o, ready_i, imm_o, tag_o, illegal_o
// slave  : the stage itself
// master : whoever drives decode side and consumes execute side
interface imm_gen_pipe_stage_if
   import risc_v_32_i_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic              flush_i;
   logic              valid_i;
   logic              ready_o;
   logic [31:0]       instr_i;
   imm_select_e       imm_sel_i;
   logic [TAG_W-1:0]  tag_i;
   logic              valid_o;
   logic              ready_i;
   logic [XLEN-1:0]   imm_o;
   logic [TAG_W-1:0]  tag_o;
   logic              illegal_o;

   modport slave (
      input  flush_i, valid_i, instr_i, imm_sel_i, tag_i, ready_i,
      output ready_o, valid_o, imm_o, tag_o, illegal_o
   );

   modport master (
      output flush_i, valid_i, instr_i, imm_sel_i, tag_i, ready_i,
      input  ready_o, valid_o, imm_o, tag_o, illegal_o
   );
endinterface

// File: rtl/imm_gen_pipe_stage_decode.sv
// imm_decode_comb: purely combinational instruction -> XLEN immediate.
//   i_instr   : instruction word (opcode bits [6:0] not used)
//   i_sel     : immediate format
//   o_imm     : sign/zero-extended immediate
//   o_illegal : selector was IMM_UNKNOWN_TYPE
module imm_decode_comb
   import risc_v_32_i_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_instr,
   input  imm_select_e     i_sel,
   output logic [XLEN-1:0] o_imm,
   output logic            o_illegal
);
   // Every format is built at 64 bits and truncated, so one expression
   // serves both XLEN=32 and XLEN=64.
   logic [63:0] w_imm64;
   logic        w_unused;

   always_comb begin
      w_imm64   = '0;
      o_illegal = 1'b0;
      unique case (i_sel)
         IMM_I_TYPE:     w_imm64 = {{52{i_instr[31]}}, i_instr[31:20]};
         IMM_S_TYPE:     w_imm64 = {{52{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         IMM_B_TYPE:     w_imm64 = {{52{i_instr[31]}}, i_instr[7], i_instr[30:25],
                                    i_instr[11:8], 1'b0};
         IMM_J_TYPE:     w_imm64 = {{44{i_instr[31]}}, i_instr[19:12], i_instr[20],
                                    i_instr[30:21], 1'b0};
         IMM_U_TYPE:     w_imm64 = {{32{i_instr[31]}}, i_instr[31:12], 12'b0};
         IMM_Z_TYPE:     w_imm64 = {59'b0, i_instr[19:15]};
         // RV64 shift amounts are six bits; RV32 ignores instr[25].
         IMM_SHAMT_TYPE: w_imm64 = (XLEN == 64) ? {58'b0, i_instr[25:20]}
                                                : {59'b0, i_instr[24:20]};
         default:        o_illegal = 1'b1;
      endcase
   end

   assign o_imm    = w_imm64[XLEN-1:0];
   assign w_unused = ^{i_instr[6:0], w_imm64};
endmodule

// File: rtl/imm_gen_pipe_stage.sv
// imm_gen_pipe_stage: registered immediate generation between decode and
// execute with a two-entry skid buffer.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : handshake bundle (slave side), see imm_gen_pipe_stage_if
// M (main) drives the outputs; S (skid) catches an entry accepted while M is
// stalled. ready_o depends only on state, never on ready_i.
module imm_gen_pipe_stage
   import risc_v_32_i_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input logic                 clk_i,
   input logic                 rst_i,
   imm_gen_pipe_stage_if.slave bus
);
   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe_stage: XLEN must be 32 or 64");
   end
   if (TAG_W < 1 || TAG_W > TAG_MAX_W) begin : g_bad_tag
      $error("imm_gen_pipe_stage: TAG_W out of range");
   end

   logic [XLEN-1:0] w_imm;
   logic            w_illegal;
   imm_entry_t      w_new;
   imm_entry_t      r_m, r_s;
   skid_state_e     r_state, w_state_nxt;
   logic            w_ready, w_accept, w_drain;
   logic            w_ld_m, w_m_from_s, w_ld_s;
   logic            w_unused;

   imm_decode_comb #(.XLEN(XLEN)) u_dec (
      .i_instr   (bus.instr_i),
      .i_sel     (bus.imm_sel_i),
      .o_imm     (w_imm),
      .o_illegal (w_illegal)
   );

   assign w_new = '{imm:     IMM_MAX_W'(w_imm),
                    tag:     TAG_MAX_W'(bus.tag_i),
                    illegal: w_illegal};

   assign w_ready  = (r_state != ST_FULL);
   assign w_accept = bus.valid_i & w_ready;
   assign w_drain  = (r_state != ST_EMPTY) & bus.ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= ST_EMPTY;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ld_m      = 1'b0;
      w_m_from_s  = 1'b0;
      w_ld_s      = 1'b0;
      unique case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_ld_m      = 1'b1;
               w_state_nxt = ST_ONE;
            end
         end
         ST_ONE: begin
            if (w_accept && !w_drain) begin
               w_ld_s      = 1'b1;
               w_state_nxt = ST_FULL;
            end else if (w_accept && w_drain) begin
               w_ld_m      = 1'b1;
            end else if (w_drain) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // ready_o is low here, so no accept can coincide with this move.
            if (w_drain) begin
               w_m_from_s  = 1'b1;
               w_state_nxt = ST_ONE;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      // Flush wins over everything; data registers just hold.
      if (bus.flush_i) begin
         w_state_nxt = ST_EMPTY;
         w_ld_m      = 1'b0;
         w_m_from_s  = 1'b0;
         w_ld_s      = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_m <= '0;
         r_s <= '0;
      end else begin
         if (w_ld_m)          r_m <= w_new;
         else if (w_m_from_s) r_m <= r_s;
         if (w_ld_s)          r_s <= w_new;
      end
   end

   assign bus.ready_o   = w_ready;
   assign bus.valid_o   = (r_state != ST_EMPTY);
   assign bus.imm_o     = r_m.imm[XLEN-1:0];
   assign bus.tag_o     = r_m.tag[TAG_W-1:0];
   assign bus.illegal_o = r_m.illegal;
   assign w_unused      = ^{r_m.imm, r_m.tag};
endmodule
